stepper_pulse_driver: RTL and testbench

Consumes the per-move step counts and directions from the SCARA controller. Turns them into STEP/DIR pulse trains for the two arm stepper drivers, running both axes in parallel. Returns `stepperReady` to the controller so it can accept the next move. It sits directly downstream of the controller and directly upstream of the external driver pins.

---
 rtl/scara_pkg.sv | 19 +
 rtl/stepper_pulse_driver_if.sv | 26 ++
 rtl/step_axis.sv | 46 ++++
 rtl/stepper_pulse_driver.sv | 135 +++++++++++++
 tb/tb_stepper_pulse_driver.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/scara_pkg.sv
// Shared state encoding, step-count width and default timing for the SCARA stepper pulse path.
package scara_pkg;

    localparam int STEP_W          = 8;
    localparam int HALF_PERIOD_DEF = 2500;
    localparam int DIR_SETUP_DEF   = 100;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SETUP      = 2'd1,
        PULSE_HIGH = 2'd2,
        PULSE_LOW  = 2'd3
    } stepper_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/stepper_pulse_driver_if.sv
// Move request from the SCARA controller plus the STEP/DIR pin bundle of both axes.
interface stepper_pulse_driver_if;

    logic [scara_pkg::STEP_W-1:0] steps1;
    logic [scara_pkg::STEP_W-1:0] steps2;
    logic                         dir1;
    logic                         dir2;
    logic                         dataReady;
    logic                         stepPulse1;
    logic                         stepPulse2;
    logic                         dirOut1;
    logic                         dirOut2;
    logic                         stepperReady;
    logic                         busy;

    modport master (
        output steps1, steps2, dir1, dir2, dataReady,
        input  stepPulse1, stepPulse2, dirOut1, dirOut2, stepperReady, busy
    );

    modport slave (
        input  steps1, steps2, dir1, dir2, dataReady,
        output stepPulse1, stepPulse2, dirOut1, dirOut2, stepperReady, busy
    );

endinterface

// File: rtl/step_axis.sv
// One axis: remaining-step counter and STEP pin. The pin is registered from next-state values,
// so it rises and falls on the same clock edge as the shared FSM phase change.
module step_axis
    import scara_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [STEP_W-1:0] steps_i,
    input  logic              dec_i,
    input  logic              high_nxt_i,
    output logic              zero_o,
    output logic              zero_nxt_o,
    output logic              pulse_o
);

    logic [STEP_W-1:0] count_q, count_d;
    logic              pulse_q, pulse_d;

    // A zero count is never decremented, so a short axis simply idles at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = steps_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    assign pulse_d = high_nxt_i & (count_d != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            count_q <= count_d;
            pulse_q <= pulse_d;
        end
    end

    assign zero_o     = (count_q == '0);
    assign zero_nxt_o = (count_d == '0);
    assign pulse_o    = pulse_q;

endmodule

// File: rtl/stepper_pulse_driver.sv
// Two-axis STEP/DIR generator: loads on a dataReady rising edge seen in IDLE, holds DIR for
// DIR_SETUP cycles, then emits max(steps1,steps2) shared-edge pulses; edges while busy are dropped.
module stepper_pulse_driver
    import scara_pkg::*;
#(
    parameter int HALF_PERIOD = HALF_PERIOD_DEF,
    parameter int DIR_SETUP   = DIR_SETUP_DEF
)
(
    input  logic                    clk,
    input  logic                    reset,
    stepper_pulse_driver_if.slave   bus
);

    localparam int TMR_MAX = max2(HALF_PERIOD, DIR_SETUP);
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] HP_LOAD = TMR_W'(HALF_PERIOD - 1);
    localparam logic [TMR_W-1:0] DS_LOAD = TMR_W'(DIR_SETUP - 1);

    stepper_state_t    state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              prev_q;
    logic              dir1_q, dir2_q;
    logic              rdy_q, busy_q;

    logic              rise, load, dec, tmr_zero, high_nxt;
    logic              zero1, zero2, zero1_nxt, zero2_nxt;
    logic              pulse1, pulse2;

    assign rise     = bus.dataReady & ~prev_q;
    assign tmr_zero = (timer_q == '0);
    assign load     = (state_q == IDLE) && rise;
    assign dec      = (state_q == PULSE_LOW) && tmr_zero;
    assign high_nxt = (state_d == PULSE_HIGH);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = SETUP;
                    timer_d = DS_LOAD;
                end
            end
            SETUP: begin
                if (!tmr_zero) begin
                    timer_d = timer_q - 1'b1;
                end else if (zero1 && zero2) begin
                    state_d = IDLE;
                end else begin
                    state_d = PULSE_HIGH;
                    timer_d = HP_LOAD;
                end
            end
            PULSE_HIGH: begin
                if (!tmr_zero) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    state_d = PULSE_LOW;
                    timer_d = HP_LOAD;
                end
            end
            PULSE_LOW: begin
                // Exit decision uses post-decrement counts so the last low phase ends the move.
                if (!tmr_zero) begin
                    timer_d = timer_q - 1'b1;
                end else if (zero1_nxt && zero2_nxt) begin
                    state_d = IDLE;
                end else begin
                    state_d = PULSE_HIGH;
                    timer_d = HP_LOAD;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            prev_q  <= 1'b0;
            dir1_q  <= 1'b0;
            dir2_q  <= 1'b0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            prev_q  <= bus.dataReady;
            if (load) begin
                dir1_q <= bus.dir1;
                dir2_q <= bus.dir2;
            end
            rdy_q   <= (state_d == IDLE);
            busy_q  <= (state_d != IDLE);
        end
    end

    step_axis u_axis1 (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load),
        .steps_i    (bus.steps1),
        .dec_i      (dec),
        .high_nxt_i (high_nxt),
        .zero_o     (zero1),
        .zero_nxt_o (zero1_nxt),
        .pulse_o    (pulse1)
    );

    step_axis u_axis2 (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load),
        .steps_i    (bus.steps2),
        .dec_i      (dec),
        .high_nxt_i (high_nxt),
        .zero_o     (zero2),
        .zero_nxt_o (zero2_nxt),
        .pulse_o    (pulse2)
    );

    assign bus.stepPulse1   = pulse1;
    assign bus.stepPulse2   = pulse2;
    assign bus.dirOut1      = dir1_q;
    assign bus.dirOut2      = dir2_q;
    assign bus.stepperReady = rdy_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_stepper_pulse_driver.sv
// Bench for stepper_pulse_driver with HALF_PERIOD=4, DIR_SETUP=3: directed table, corner sequences, random moves.
module tb_stepper_pulse_driver;
    import scara_pkg::*;

    localparam int HP = 4;
    localparam int DS = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    stepper_pulse_driver_if bus ();

    stepper_pulse_driver #(.HALF_PERIOD(HP), .DIR_SETUP(DS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    logic cur_d1   = 1'b0;
    logic cur_d2   = 1'b0;
    int   bl, e1, e2;

    typedef struct {
        int   s1;
        int   s2;
        logic d1;
        logic d2;
        int   exp_len;
        int   exp_p1;
        int   exp_p2;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [5:0] outs();
        return {bus.stepperReady, bus.busy, bus.stepPulse1, bus.stepPulse2, bus.dirOut1, bus.dirOut2};
    endfunction

    // Expected pins c cycles after the accepting edge, from the move timeline.
    function automatic logic [5:0] model(int c, int s1, int s2, logic d1, logic d2);
        int   m;
        int   len;
        int   ph;
        int   k;
        logic bsy;
        logic p1;
        logic p2;
        m   = (s1 > s2) ? s1 : s2;
        len = DS + 2 * HP * m;
        bsy = (c >= 1) && (c <= len);
        p1  = 1'b0;
        p2  = 1'b0;
        if (c > DS && c <= len) begin
            ph = (c - 1 - DS) % (2 * HP);
            k  = (c - 1 - DS) / (2 * HP);
            p1 = (ph < HP) && (k < s1);
            p2 = (ph < HP) && (k < s2);
        end
        return {~bsy, bsy, p1, p2, d1, d2};
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (rdy,busy,p1,p2,d1,d2)", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_cycles(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(name, outs(), {1'b1, 1'b0, 1'b0, 1'b0, cur_d1, cur_d2});
        end
    endtask

    // Called at a negedge; returns at the negedge where stepperReady is back.
    task automatic run_move(input int s1, input int s2, input logic d1, input logic d2, input bit glitch,
                            output int busy_len, output int edges1, output int edges2);
        logic [5:0] o;
        logic       prev1;
        logic       prev2;
        int         len;
        prev1    = 1'b0;
        prev2    = 1'b0;
        busy_len = 0;
        edges1   = 0;
        edges2   = 0;
        len      = DS + 2 * HP * ((s1 > s2) ? s1 : s2);
        bus.steps1    = 8'(s1);
        bus.steps2    = 8'(s2);
        bus.dir1      = d1;
        bus.dir2      = d2;
        bus.dataReady = 1'b1;
        @(posedge clk);
        cur_d1 = d1;
        cur_d2 = d2;
        for (int c = 1; c <= len + 1; c++) begin
            @(negedge clk);
            o = outs();
            check($sformatf("move(%0d,%0d) c=%0d", s1, s2, c), o, model(c, s1, s2, d1, d2));
            if (o[4]) busy_len++;
            if (o[3] && !prev1) edges1++;
            if (o[2] && !prev2) edges2++;
            prev1 = o[3];
            prev2 = o[2];
            if (!glitch && c == 1) begin
                bus.dataReady = 1'b0;
                bus.steps1    = 8'(s1) ^ 8'hA5;
                bus.steps2    = 8'(s2) ^ 8'h5A;
                bus.dir1      = ~d1;
                bus.dir2      = ~d2;
            end
            if (glitch && c == DS + 2) begin
                bus.dataReady = 1'b0;
                bus.steps1    = 8'd9;
                bus.steps2    = 8'd9;
                bus.dir1      = ~d1;
            end
            if (glitch && c == DS + 3) bus.dataReady = 1'b1;
        end
    endtask

    initial begin
        vecs[0] = '{3,   1,   1'b1, 1'b0, 27,   3,   1};
        vecs[1] = '{0,   0,   1'b1, 1'b1, 3,    0,   0};
        vecs[2] = '{1,   4,   1'b0, 1'b1, 35,   1,   4};
        vecs[3] = '{2,   2,   1'b1, 1'b1, 19,   2,   2};
        vecs[4] = '{255, 255, 1'b0, 1'b1, 2043, 255, 255};
        vecs[5] = '{0,   5,   1'b1, 1'b0, 43,   0,   5};

        bus.steps1    = '0;
        bus.steps2    = '0;
        bus.dir1      = 1'b0;
        bus.dir2      = 1'b0;
        bus.dataReady = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", outs(), 6'b100000);
        reset = 1'b1;
        idle_cycles(20, "idle_after_reset");

        for (int i = 0; i < 6; i++) begin
            run_move(vecs[i].s1, vecs[i].s2, vecs[i].d1, vecs[i].d2, 1'b0, bl, e1, e2);
            check_int($sformatf("vec%0d busy_len", i), bl, vecs[i].exp_len);
            check_int($sformatf("vec%0d pulses1", i), e1, vecs[i].exp_p1);
            check_int($sformatf("vec%0d pulses2", i), e2, vecs[i].exp_p2);
            idle_cycles(i % 2, "gap");
        end

        // dataReady held high, plus a second edge inside the first high phase.
        run_move(2, 1, 1'b0, 1'b1, 1'b1, bl, e1, e2);
        check_int("held pulses1", e1, 2);
        check_int("held pulses2", e2, 1);
        idle_cycles(10, "held_no_retrigger");
        bus.dataReady = 1'b0;
        idle_cycles(2, "held_release");

        // Asynchronous reset in the middle of a high phase.
        bus.steps1    = 8'd5;
        bus.steps2    = 8'd3;
        bus.dir1      = 1'b1;
        bus.dir2      = 1'b1;
        bus.dataReady = 1'b1;
        @(posedge clk);
        cur_d1 = 1'b1;
        cur_d2 = 1'b1;
        for (int c = 1; c <= DS + 2; c++) begin
            @(negedge clk);
            check($sformatf("prereset c=%0d", c), outs(), model(c, 5, 3, 1'b1, 1'b1));
            if (c == 1) bus.dataReady = 1'b0;
        end
        #1 reset = 1'b0;
        #1 check("async_reset_drop", outs(), 6'b100000);
        cur_d1 = 1'b0;
        cur_d2 = 1'b0;
        @(negedge clk);
        check("held_in_reset", outs(), 6'b100000);
        reset = 1'b1;
        idle_cycles(3, "after_reset_idle");
        run_move(2, 3, 1'b0, 1'b1, 1'b0, bl, e1, e2);
        check_int("post_reset pulses1", e1, 2);
        check_int("post_reset pulses2", e2, 3);

        // Random moves with 0..3 idle cycles between them.
        for (int i = 0; i < 25; i++) begin
            int   rs1;
            int   rs2;
            logic rd1;
            logic rd2;
            rs1 = int'($urandom_range(0, 12));
            rs2 = int'($urandom_range(0, 12));
            rd1 = 1'($urandom_range(0, 1));
            rd2 = 1'($urandom_range(0, 1));
            idle_cycles(int'($urandom_range(0, 3)), "rand_gap");
            run_move(rs1, rs2, rd1, rd2, 1'b0, bl, e1, e2);
            check_int($sformatf("rand%0d pulses1", i), e1, rs1);
            check_int($sformatf("rand%0d pulses2", i), e2, rs2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
